// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over valid/ready and serialises it as
// start, DATA_BITS data bits LSB-first, optional parity, then stop bit(s).
module uart_tx #(
    parameter int BIT_PERIOD = 10,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int TW = $clog2(BIT_PERIOD);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TMAX = TW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] DMAX = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] SMAX = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [TW-1:0]        timer, timer_n;
    logic [BW-1:0]        bcnt, bcnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par, par_n;
    logic                 so_n, done_n;

    always_comb begin
        state_n = state;
        timer_n = timer + 1'b1;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        par_n   = par;
        case (state)
            IDLE: begin
                timer_n = '0;
                bcnt_n  = '0;
                if (tx_valid) begin
                    state_n = START;
                    shreg_n = tx_data;
                    par_n   = (^tx_data) ^ (PARITY_ODD != 0);
                end
            end
            START: begin
                if (timer == TMAX) begin
                    state_n = DATA;
                    timer_n = '0;
                    bcnt_n  = '0;
                end
            end
            DATA: begin
                if (timer == TMAX) begin
                    timer_n = '0;
                    shreg_n = shreg >> 1;
                    if (bcnt == DMAX) begin
                        bcnt_n  = '0;
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (timer == TMAX) begin
                    state_n = STOP;
                    timer_n = '0;
                    bcnt_n  = '0;
                end
            end
            STOP: begin
                if (timer == TMAX) begin
                    timer_n = '0;
                    if (bcnt == SMAX) begin
                        state_n = IDLE;
                        bcnt_n  = '0;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
                bcnt_n  = '0;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they describe.
        case (state_n)
            START:   so_n = 1'b0;
            DATA:    so_n = shreg_n[0];
            PARITY:  so_n = par_n;
            default: so_n = 1'b1;
        endcase
        done_n = (state_n == STOP) && (timer_n == TMAX) && (bcnt_n == SMAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            serial_out <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            bcnt       <= bcnt_n;
            shreg      <= shreg_n;
            par        <= par_n;
            serial_out <= so_n;
            tx_ready   <= (state_n == IDLE);
            tx_busy    <= (state_n != IDLE);
            tx_done    <= done_n;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E1, 8O2) share the stimulus;
// a frame-level model queues the expected line per cycle, a monitor compares.
module tb_uart_tx;
    localparam int BP = 10;
    localparam int DB = 8;
    localparam int NI = 3;
    localparam int PE [NI] = '{0, 1, 1};
    localparam int PO [NI] = '{0, 0, 1};
    localparam int SB [NI] = '{1, 1, 2};

    typedef struct packed {
        logic line;
        logic done;
        logic busy;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic [DB-1:0] tx_data;
    logic          mon_en = 1'b0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s[%0d] t=%0t got %b expected %b", nm, inst, $time, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        logic so, rdy, bsy, dn;
        exp_t q[$];

        uart_tx #(
            .BIT_PERIOD(BP), .DATA_BITS(DB), .PARITY_EN(PE[g]),
            .PARITY_ODD(PO[g]), .STOP_BITS(SB[g])
        ) dut (
            .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
            .tx_ready(rdy), .serial_out(so), .tx_busy(bsy), .tx_done(dn)
        );

        // Reference model: an idle transmitter takes tx_valid, and the whole
        // frame plus the one idle cycle before it can accept again is queued.
        always @(posedge clk) begin
            logic bits[$];
            int   nb;
            if (rst) begin
                q.delete();
            end else if (tx_valid && q.size() == 0) begin
                bits.delete();
                bits.push_back(1'b0);
                for (int i = 0; i < DB; i++) bits.push_back(tx_data[i]);
                if (PE[g] != 0)
                    bits.push_back((($countones(tx_data) % 2) != 0) ^ (PO[g] != 0));
                for (int s = 0; s < SB[g]; s++) bits.push_back(1'b1);
                nb = bits.size();
                for (int b = 0; b < nb; b++)
                    for (int c = 0; c < BP; c++)
                        q.push_back('{line: bits[b], done: (b == nb - 1 && c == BP - 1), busy: 1'b1});
                q.push_back('{line: 1'b1, done: 1'b0, busy: 1'b0});
            end
        end

        always @(negedge clk) begin
            exp_t e;
            if (mon_en) begin
                if (q.size() > 0) e = q.pop_front();
                else e = '{line: 1'b1, done: 1'b0, busy: 1'b0};
                chk("serial_out", g, so, e.line);
                chk("tx_done", g, dn, e.done);
                chk("tx_busy", g, bsy, e.busy);
                chk("tx_ready", g, rdy, !e.busy);
            end
        end
    end

    task automatic send(input logic [DB-1:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        tx_data  = DB'($urandom);
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);

        // single frame 0x55
        send(8'h55);
        cyc(130);

        // back-to-back with tx_valid held, data changing mid-frame
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        cyc(50);
        tx_data = 8'h0F;
        cyc(55);
        tx_valid = 1'b0;
        cyc(250);

        // parity pattern
        send(8'h07);
        cyc(130);

        // reset mid-frame, then a clean send
        send(8'h00);
        cyc(44);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        send(8'h3C);
        cyc(130);

        // valid pulse while busy is ignored
        send(8'h96);
        cyc(30);
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        cyc(120);

        // randomized traffic
        for (int i = 0; i < 25; i++) begin
            tx_data  = DB'($urandom);
            tx_valid = 1'b1;
            cyc($urandom_range(1, 3));
            tx_valid = 1'b0;
            cyc($urandom_range(5, 60));
            tx_data = DB'($urandom);
            if ($urandom_range(0, 1) != 0) begin
                tx_valid = 1'b1;
                cyc(1);
                tx_valid = 1'b0;
            end
            cyc($urandom_range(60, 140));
        end
        cyc(150);

        chk("drained", 0, gi[0].q.size() == 0, 1'b1);
        chk("drained", 1, gi[1].q.size() == 0, 1'b1);
        chk("drained", 2, gi[2].q.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
